load_store_unit: RTL and testbench

//  Initiator side of the data_memory port. Takes one load/store request from the MEM stage,

---
 rtl/load_store_unit_if.sv | 23 ++
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response channel between the MEM stage (master) and the load/store unit (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access to a word-only data memory, sub-word stores via RMW.
// Optional LSU_STATS_EN adds saturating load/store/error counters.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64
`ifdef LSU_STATS_EN
  , parameter int unsigned COUNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   lsu,
  output logic [31:0]        address,
  output logic [31:0]        write_data,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [31:0]        read_data
`ifdef LSU_STATS_EN
  , output logic [COUNT_W-1:0] stat_loads
  , output logic [COUNT_W-1:0] stat_stores
  , output logic [COUNT_W-1:0] stat_errors
`endif
);

  localparam int unsigned DATA_W     = 32;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;

  logic [1:0]        req_err;
  logic [4:0]        lane_sh;
  logic [DATA_W-1:0] rd_lane, lane_mask, merged, rd_ext;

`ifdef LSU_STATS_EN
  logic [COUNT_W-1:0] loads_q, loads_d, stores_q, stores_d, errors_q, errors_d;
`endif

  // Request legality: alignment/size takes priority over range
  always_comb begin
    req_err = 2'b00;
    if (lsu.req_size == 2'b11 ||
        (lsu.req_size == SZ_HALF && lsu.req_addr[0]) ||
        (lsu.req_size == SZ_WORD && lsu.req_addr[1:0] != 2'b00)) begin
      req_err = 2'b01;
    end else if (lsu.req_addr >= ADDR_LIMIT) begin
      req_err = 2'b10;
    end
  end

  assign lane_sh   = {addr_q[1:0], 3'b000};
  assign rd_lane   = read_data >> lane_sh;
  assign lane_mask = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign merged    = (read_data & ~lane_mask) | ((data_q << lane_sh) & lane_mask);

  always_comb begin
    rd_ext = read_data;
    case (size_q)
      SZ_BYTE: rd_ext = unsigned_q ? {24'h0, rd_lane[7:0]}
                                   : {{24{rd_lane[7]}}, rd_lane[7:0]};
      SZ_HALF: rd_ext = unsigned_q ? {16'h0, rd_lane[15:0]}
                                   : {{16{rd_lane[15]}}, rd_lane[15:0]};
      default: rd_ext = read_data;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    write_d      = write_q;
    data_d       = data_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
`ifdef LSU_STATS_EN
    loads_d      = loads_q;
    stores_d     = stores_q;
    errors_d     = errors_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (lsu.req_valid) begin
          addr_d     = lsu.req_addr;
          size_d     = lsu.req_size;
          unsigned_d = lsu.req_unsigned;
          write_d    = lsu.req_write;
          data_d     = lsu.req_wdata;
          if (req_err != 2'b00) begin
            state_d      = ST_RESP;
            resp_err_d   = req_err;
            resp_rdata_d = '0;
`ifdef LSU_STATS_EN
            if (!(&errors_q)) errors_d = errors_q + COUNT_W'(1);
`endif
          end else if (lsu.req_write && lsu.req_size == SZ_WORD) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (write_q) begin
          data_d  = merged;
          state_d = ST_WR;
        end else begin
          resp_rdata_d = rd_ext;
          resp_err_d   = 2'b00;
          state_d      = ST_RESP;
`ifdef LSU_STATS_EN
          if (!(&loads_q)) loads_d = loads_q + COUNT_W'(1);
`endif
        end
      end
      ST_WR: begin
        resp_rdata_d = '0;
        resp_err_d   = 2'b00;
        state_d      = ST_RESP;
`ifdef LSU_STATS_EN
        if (!(&stores_q)) stores_d = stores_q + COUNT_W'(1);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    resp_valid_d = (state_d == ST_RESP);
    req_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      write_q      <= 1'b0;
      data_q       <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
`ifdef LSU_STATS_EN
      loads_q      <= '0;
      stores_q     <= '0;
      errors_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      write_q      <= write_d;
      data_q       <= data_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
`ifdef LSU_STATS_EN
      loads_q      <= loads_d;
      stores_q     <= stores_d;
      errors_q     <= errors_d;
`endif
    end
  end

  // Memory port decoded from registered state; enables blocked during reset
  assign MemRead    = (state_q == ST_RD) & ~reset;
  assign MemWrite   = (state_q == ST_WR) & ~reset;
  assign address    = (state_q == ST_RD || state_q == ST_WR) ? {addr_q[31:2], 2'b00} : '0;
  assign write_data = (state_q == ST_WR) ? data_q : '0;

  assign lsu.req_ready  = req_ready_q;
  assign lsu.resp_valid = resp_valid_q;
  assign lsu.resp_rdata = resp_rdata_q;
  assign lsu.resp_err   = resp_err_q;

`ifdef LSU_STATS_EN
  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses against a word-array model.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, write_data, read_data;
  logic        MemWrite, MemRead;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errors;
  int          m_loads = 0, m_stores = 0, m_errors = 0;
`endif

  load_store_unit_if lsu_bus ();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .lsu        (lsu_bus.slave),
    .address    (address),
    .write_data (write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .read_data  (read_data)
`ifdef LSU_STATS_EN
    , .stat_loads  (stat_loads)
    , .stat_stores (stat_stores)
    , .stat_errors (stat_errors)
`endif
  );

  always #5 clk = ~clk;

  // Attached data memory and the reference copy the model predicts
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  assign read_data = mem[address[7:2]];
  always @(posedge clk) if (MemWrite) mem[address[7:2]] <= write_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: outcome of one request computed from the byte-addressed rules
  task automatic model_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [1:0] err, output logic [31:0] rd,
                           output int lat, output int nrd, output int nwr);
    int unsigned nb, sh, idx;
    logic [31:0] low_mask, word, v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = 2'b00; rd = '0; lat = 0; nrd = 0; nwr = 0;
    if (sz == 2'd3 || (a % nb) != 0) err = 2'b01;
    else if (a >= 4 * MEM_WORDS) err = 2'b10;
    if (err != 2'b00) begin
      lat = 1;
`ifdef LSU_STATS_EN
      m_errors++;
`endif
      return;
    end
    idx      = a / 4;
    sh       = 8 * (a % 4);
    low_mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    word     = ref_mem[idx];
    if (!wr) begin
      v = (word >> sh) & low_mask;
      if (!uns && nb < 4 && v > (low_mask >> 1)) v = v - (low_mask + 32'd1);
      rd = v; lat = 2; nrd = 1;
`ifdef LSU_STATS_EN
      m_loads++;
`endif
    end else begin
      ref_mem[idx] = (word & ~(low_mask << sh)) | ((wd & low_mask) << sh);
      lat = (nb == 4) ? 2 : 3; nrd = (nb == 4) ? 0 : 1; nwr = 1;
`ifdef LSU_STATS_EN
      m_stores++;
`endif
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  e_err;
    logic [31:0] e_rd, bus_addr, idle_bus;
    int          e_lat, e_nrd, e_nwr, lat, nrd, nwr;
    lat = 0; nrd = 0; nwr = 0; bus_addr = '0; idle_bus = '0;
    model_req(wr, sz, uns, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    check("ready_idle", 32'(lsu_bus.req_ready), 32'd1);
    lsu_bus.req_valid = 1'b1; lsu_bus.req_write = wr; lsu_bus.req_size = sz;
    lsu_bus.req_unsigned = uns; lsu_bus.req_addr = a; lsu_bus.req_wdata = wd;
    @(posedge clk); #1;
    // Junk while busy must be ignored
    lsu_bus.req_addr = $urandom; lsu_bus.req_wdata = $urandom; lsu_bus.req_write = ~wr;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (MemRead)  begin nrd++; bus_addr = address; end
      if (MemWrite) begin nwr++; bus_addr = address; end
      if (lsu_bus.resp_valid) begin
        lat = c; last_rdata = lsu_bus.resp_rdata; last_err = lsu_bus.resp_err;
        idle_bus = address | write_data | 32'(MemRead) | 32'(MemWrite);
        lsu_bus.req_valid = 1'b0;
      end
    end
    lsu_bus.req_valid = 1'b0;
    check("latency",  32'(lat), 32'(e_lat));
    check("resp_err", 32'(last_err), 32'(e_err));
    check("rdata",    last_rdata, e_rd);
    check("n_read",   32'(nrd), 32'(e_nrd));
    check("n_write",  32'(nwr), 32'(e_nwr));
    check("bus_addr", bus_addr, (e_nrd + e_nwr > 0) ? {a[31:2], 2'b00} : 32'h0);
    check("resp_bus_idle", idle_bus, 32'h0);
    @(negedge clk);
    check("resp_pulse", 32'({lsu_bus.resp_valid, lsu_bus.req_ready}), 32'b01);
    check("rdata_hold", lsu_bus.resp_rdata, e_rd);
  endtask

  logic [1:0]  r_sz;
  logic [31:0] r_a;
  int          hs, resps;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    lsu_bus.req_valid = 1'b0; lsu_bus.req_write = 1'b0; lsu_bus.req_size = 2'b00;
    lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = '0; lsu_bus.req_wdata = '0;
    last_rdata = '0; last_err = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(lsu_bus.req_ready), 32'd1);
    check("rst_resp",  32'(lsu_bus.resp_valid) | lsu_bus.resp_rdata | 32'(lsu_bus.resp_err), 32'h0);
    check("rst_mem_en", 32'({MemRead, MemWrite}), 32'h0);

    // Word store then load back
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("t1_mem4", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("t1_lw", last_rdata, 32'hDEADBEEF);

    // Byte store read-modify-write
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    check("t2_mem4", mem[4], 32'h11AA3344);

    // Extension
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0); check("t3_lb",  last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0); check("t3_lbu", last_rdata, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0); check("t3_lh0", last_rdata, 32'h00007F01);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0); check("t3_lh2", last_rdata, 32'hFFFF80FF);

    // Errors
    do_req(1'b0, 2'b10, 1'b0, 32'h12,  32'h0); check("t4_misal", 32'(last_err), 32'd1);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h5); check("t4_range", 32'(last_err), 32'd2);
    do_req(1'b0, 2'b11, 1'b0, 32'h20,  32'h0); check("t4_size",  32'(last_err), 32'd1);

    // Reset during the WR cycle of a half-word RMW
    @(negedge clk);
    lsu_bus.req_valid = 1'b1; lsu_bus.req_write = 1'b1; lsu_bus.req_size = 2'b01;
    lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = 32'h14; lsu_bus.req_wdata = 32'h0000BEEF;
    @(posedge clk); #1 lsu_bus.req_valid = 1'b0;
    @(negedge clk);
    check("t5_rd", 32'(MemRead), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t5_no_write", 32'(MemWrite), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
`ifdef LSU_STATS_EN
    m_loads = 0; m_stores = 0; m_errors = 0;
`endif
    @(negedge clk);
    check("t5_ready", 32'(lsu_bus.req_ready), 32'd1);
    check("t5_resp_clr", 32'(lsu_bus.resp_valid) | lsu_bus.resp_rdata | 32'(lsu_bus.resp_err), 32'h0);
    check("t5_mem5", mem[5], ref_mem[5]);

    // Back-to-back loads with req_valid held
    hs = 0; resps = 0;
    lsu_bus.req_valid = 1'b1; lsu_bus.req_write = 1'b0; lsu_bus.req_size = 2'b10;
    lsu_bus.req_unsigned = 1'b0; lsu_bus.req_addr = 32'h10;
    for (int c = 0; c < 40 && resps < 4; c++) begin
      if (lsu_bus.resp_valid) begin
        resps++;
        check("t6_rdata", lsu_bus.resp_rdata, ref_mem[4]);
      end
      if (MemRead || lsu_bus.resp_valid) check("t6_busy", 32'(lsu_bus.req_ready), 32'd0);
      if (lsu_bus.req_valid && lsu_bus.req_ready) hs++;
      @(posedge clk); #1;
      if (hs == 4) lsu_bus.req_valid = 1'b0;
      @(negedge clk);
    end
    lsu_bus.req_valid = 1'b0;
    check("t6_handshakes", 32'(hs), 32'd4);
    check("t6_resps", 32'(resps), 32'd4);
`ifdef LSU_STATS_EN
    m_loads += 4;
`endif

    // Randomized accesses
    for (int n = 0; n < 200; n++) begin
      r_sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_a  = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
      if ($urandom_range(0, 7) != 0) begin
        if (r_sz == 2'b01) r_a[0] = 1'b0;
        if (r_sz == 2'b10) r_a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) r_a = r_a + 32'(4 * MEM_WORDS) * 32'($urandom_range(1, 1000));
      do_req(1'($urandom), r_sz, 1'($urandom), r_a, $urandom);
    end

    for (int i = 0; i < MEM_WORDS; i++) check("final_mem", mem[i], ref_mem[i]);
`ifdef LSU_STATS_EN
    check("stat_loads",  32'(stat_loads),  32'(m_loads));
    check("stat_stores", 32'(stat_stores), 32'(m_stores));
    check("stat_errors", 32'(stat_errors), 32'(m_errors));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
